hue_div_pipe: RTL and testbench



---
 rtl/hue_pkg.sv | 20 ++
 rtl/hue_div_pipe_if.sv | 27 ++
 rtl/hue_div_step.sv | 91 +++++++++
 rtl/hue_div_pipe.sv | 172 +++++++++++++++++
 tb/tb_hue_div_pipe.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hue_pkg.sv
// Shared width defaults and pipeline helpers for the hue divide stage.
// Downstream delay-matching logic calls hue_div_latency to align with the quotient.
package hue_pkg;

  localparam int HUE_DIVIDEND_W = 9;
  localparam int HUE_DIVISOR_W  = 8;
  localparam int HUE_FRAC_W     = 8;
  localparam int HUE_ROUND      = 0;
  localparam int HUE_USER_W     = 1;
  localparam int HUE_Q_W        = HUE_DIVIDEND_W + HUE_FRAC_W;

  function automatic int hue_q_w(input int dividend_w, input int frac_w);
    return dividend_w + frac_w;
  endfunction

  function automatic int hue_div_latency(input int dividend_w, input int frac_w);
    return dividend_w + frac_w + 2;
  endfunction

endpackage

// File: rtl/hue_div_pipe_if.sv
// Sample-in / result-out bundle of the hue divider.
// A sample is taken on any enabled edge with valid=1 (there is no ready); a result is new only on enabled edges.
interface hue_div_pipe_if
  import hue_pkg::*;
#(
  parameter int DIVIDEND_W = HUE_DIVIDEND_W,
  parameter int DIVISOR_W  = HUE_DIVISOR_W,
  parameter int FRAC_W     = HUE_FRAC_W,
  parameter int USER_W     = HUE_USER_W
) ();
  logic                         en;
  logic                         flush;
  logic                         valid;
  logic [DIVIDEND_W-1:0]        dividend;
  logic [DIVISOR_W-1:0]         divisor;
  logic [USER_W-1:0]            user;
  logic                         o_valid;
  logic [DIVIDEND_W+FRAC_W:0]   o_quot;
  logic                         o_dbz;
  logic [USER_W-1:0]            o_user;
  logic                         o_busy;

  modport master (output en, flush, valid, dividend, divisor, user,
                  input  o_valid, o_quot, o_dbz, o_user, o_busy);
  modport slave  (input  en, flush, valid, dividend, divisor, user,
                  output o_valid, o_quot, o_dbz, o_user, o_busy);
endinterface

// File: rtl/hue_div_step.sv
// One registered restoring-division step: shifts in the next numerator bit
// and produces one quotient bit, carrying the sample context alongside.
module hue_div_step #(
  parameter int DIVISOR_W = 8,
  parameter int Q_W       = 17,
  parameter int USER_W    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_en,
  input  logic                 i_flush,
  input  logic                 i_valid,
  input  logic [DIVISOR_W:0]   i_rem,
  input  logic [Q_W-1:0]       i_num,
  input  logic [Q_W-1:0]       i_quot,
  input  logic [DIVISOR_W-1:0] i_divisor,
  input  logic                 i_sign,
  input  logic                 i_dbz,
  input  logic [USER_W-1:0]    i_user,
  output logic                 o_valid,
  output logic [DIVISOR_W:0]   o_rem,
  output logic [Q_W-1:0]       o_num,
  output logic [Q_W-1:0]       o_quot,
  output logic [DIVISOR_W-1:0] o_divisor,
  output logic                 o_sign,
  output logic                 o_dbz,
  output logic [USER_W-1:0]    o_user
);
  localparam int RW = DIVISOR_W + 1;

  logic [RW:0]          trial;
  logic                 ge;
  logic                 valid_q, valid_d;
  logic [RW-1:0]        rem_q, rem_d;
  logic [Q_W-1:0]       num_q, num_d;
  logic [Q_W-1:0]       quot_q, quot_d;
  logic [DIVISOR_W-1:0] div_q, div_d;
  logic                 sign_q, sign_d;
  logic                 dbz_q, dbz_d;
  logic [USER_W-1:0]    user_q, user_d;

  always_comb begin
    // Remainder stays below the divisor, so the widened trial never overflows.
    trial   = {i_rem, i_num[Q_W-1]};
    ge      = trial >= {2'b00, i_divisor};
    valid_d = valid_q;
    rem_d   = rem_q;
    num_d   = num_q;
    quot_d  = quot_q;
    div_d   = div_q;
    sign_d  = sign_q;
    dbz_d   = dbz_q;
    user_d  = user_q;
    if (i_flush) begin
      valid_d = 1'b0;
    end else if (i_en) begin
      valid_d = i_valid;
      rem_d   = ge ? RW'(trial - {2'b00, i_divisor}) : RW'(trial);
      num_d   = i_num << 1;
      quot_d  = Q_W'({i_quot, ge});
      div_d   = i_divisor;
      sign_d  = i_sign;
      dbz_d   = i_dbz;
      user_d  = i_user;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) valid_q <= 1'b0;
    else         valid_q <= valid_d;
  end

  always_ff @(posedge i_clk) begin
    rem_q  <= rem_d;
    num_q  <= num_d;
    quot_q <= quot_d;
    div_q  <= div_d;
    sign_q <= sign_d;
    dbz_q  <= dbz_d;
    user_q <= user_d;
  end

  assign o_valid   = valid_q;
  assign o_rem     = rem_q;
  assign o_num     = num_q;
  assign o_quot    = quot_q;
  assign o_divisor = div_q;
  assign o_sign    = sign_q;
  assign o_dbz     = dbz_q;
  assign o_user    = user_q;
endmodule

// File: rtl/hue_div_pipe.sv
// Fully pipelined signed / unsigned fixed-point divider for the hue path:
// input conditioning, Q_W restoring steps, then rounding, sign and zero-divisor handling.
module hue_div_pipe
  import hue_pkg::*;
#(
  parameter int DIVIDEND_W = HUE_DIVIDEND_W,
  parameter int DIVISOR_W  = HUE_DIVISOR_W,
  parameter int FRAC_W     = HUE_FRAC_W,
  parameter int ROUND      = HUE_ROUND,
  parameter int USER_W     = HUE_USER_W
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic                       i_en,
  input  logic                       i_flush,
  input  logic                       i_valid,
  input  logic [DIVIDEND_W-1:0]      i_dividend,
  input  logic [DIVISOR_W-1:0]       i_divisor,
  input  logic [USER_W-1:0]          i_user,
  output logic                       o_valid,
  output logic [DIVIDEND_W+FRAC_W:0] o_quot,
  output logic                       o_dbz,
  output logic [USER_W-1:0]          o_user,
  output logic                       o_busy
);
  localparam int Q_W = hue_q_w(DIVIDEND_W, FRAC_W);
  localparam int RW  = DIVISOR_W + 1;

  logic [DIVIDEND_W-1:0] in_mag;
  logic                  s0_valid_q, s0_valid_d;
  logic                  s0_sign_q, s0_sign_d;
  logic                  s0_dbz_q, s0_dbz_d;
  logic [Q_W-1:0]        s0_num_q, s0_num_d;
  logic [DIVISOR_W-1:0]  s0_div_q, s0_div_d;
  logic [USER_W-1:0]     s0_user_q, s0_user_d;

  // Magnitude is treated as unsigned, so the most negative dividend stays exact.
  always_comb begin
    in_mag     = i_dividend[DIVIDEND_W-1] ? DIVIDEND_W'(-i_dividend) : i_dividend;
    s0_valid_d = s0_valid_q;
    s0_sign_d  = s0_sign_q;
    s0_dbz_d   = s0_dbz_q;
    s0_num_d   = s0_num_q;
    s0_div_d   = s0_div_q;
    s0_user_d  = s0_user_q;
    if (i_flush) begin
      s0_valid_d = 1'b0;
    end else if (i_en) begin
      s0_valid_d = i_valid;
      s0_sign_d  = i_dividend[DIVIDEND_W-1];
      s0_dbz_d   = (i_divisor == '0);
      s0_num_d   = Q_W'(in_mag) << FRAC_W;
      s0_div_d   = i_divisor;
      s0_user_d  = i_user;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) s0_valid_q <= 1'b0;
    else         s0_valid_q <= s0_valid_d;
  end

  always_ff @(posedge i_clk) begin
    s0_sign_q <= s0_sign_d;
    s0_dbz_q  <= s0_dbz_d;
    s0_num_q  <= s0_num_d;
    s0_div_q  <= s0_div_d;
    s0_user_q <= s0_user_d;
  end

  logic [RW-1:0]        rem_s  [Q_W+1];
  logic [Q_W-1:0]       num_s  [Q_W+1];
  logic [Q_W-1:0]       quot_s [Q_W+1];
  logic [DIVISOR_W-1:0] div_s  [Q_W+1];
  logic [USER_W-1:0]    user_s [Q_W+1];
  logic [Q_W:0]         valid_s, sign_s, dbz_s;

  assign rem_s[0]   = '0;
  assign quot_s[0]  = '0;
  assign num_s[0]   = s0_num_q;
  assign div_s[0]   = s0_div_q;
  assign user_s[0]  = s0_user_q;
  assign valid_s[0] = s0_valid_q;
  assign sign_s[0]  = s0_sign_q;
  assign dbz_s[0]   = s0_dbz_q;

  for (genvar k = 0; k < Q_W; k++) begin : g_step
    hue_div_step #(
      .DIVISOR_W (DIVISOR_W),
      .Q_W       (Q_W),
      .USER_W    (USER_W)
    ) u_step (
      .i_clk     (i_clk),
      .i_rstn    (i_rstn),
      .i_en      (i_en),
      .i_flush   (i_flush),
      .i_valid   (valid_s[k]),
      .i_rem     (rem_s[k]),
      .i_num     (num_s[k]),
      .i_quot    (quot_s[k]),
      .i_divisor (div_s[k]),
      .i_sign    (sign_s[k]),
      .i_dbz     (dbz_s[k]),
      .i_user    (user_s[k]),
      .o_valid   (valid_s[k+1]),
      .o_rem     (rem_s[k+1]),
      .o_num     (num_s[k+1]),
      .o_quot    (quot_s[k+1]),
      .o_divisor (div_s[k+1]),
      .o_sign    (sign_s[k+1]),
      .o_dbz     (dbz_s[k+1]),
      .o_user    (user_s[k+1])
    );
  end

  logic                 rnd;
  logic [Q_W-1:0]       mag;
  logic [Q_W:0]         q_ext, q_signed;
  logic                 out_valid_q, out_valid_d;
  logic [Q_W:0]         out_quot_q, out_quot_d;
  logic                 out_dbz_q, out_dbz_d;
  logic [USER_W-1:0]    out_user_q, out_user_d;
  logic                 busy_q, busy_d;

  // Magnitude peaks at 2^(Q_W-1), so the rounding carry always fits in Q_W bits.
  always_comb begin
    rnd         = (ROUND != 0) && ({rem_s[Q_W], 1'b0} >= {2'b00, div_s[Q_W]});
    mag         = quot_s[Q_W] + Q_W'(rnd);
    q_ext       = {1'b0, mag};
    q_signed    = sign_s[Q_W] ? -q_ext : q_ext;
    out_valid_d = out_valid_q;
    out_quot_d  = out_quot_q;
    out_dbz_d   = out_dbz_q;
    out_user_d  = out_user_q;
    busy_d      = busy_q;
    if (i_flush) begin
      out_valid_d = 1'b0;
      out_quot_d  = '0;
      out_dbz_d   = 1'b0;
      out_user_d  = '0;
      busy_d      = 1'b0;
    end else if (i_en) begin
      out_valid_d = valid_s[Q_W];
      out_quot_d  = (valid_s[Q_W] && !dbz_s[Q_W]) ? q_signed : '0;
      out_dbz_d   = valid_s[Q_W] && dbz_s[Q_W];
      out_user_d  = valid_s[Q_W] ? user_s[Q_W] : '0;
      busy_d      = i_valid || (|valid_s);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      out_valid_q <= 1'b0;
      out_quot_q  <= '0;
      out_dbz_q   <= 1'b0;
      out_user_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_quot_q  <= out_quot_d;
      out_dbz_q   <= out_dbz_d;
      out_user_q  <= out_user_d;
      busy_q      <= busy_d;
    end
  end

  assign o_valid = out_valid_q;
  assign o_quot  = out_quot_q;
  assign o_dbz   = out_dbz_q;
  assign o_user  = out_user_q;
  assign o_busy  = busy_q;
endmodule

// File: tb/tb_hue_div_pipe.sv
// Self-checking bench: truncating and rounding dividers share one stimulus stream,
// results are matched in order against hand values and an integer reference.
module tb_hue_div_pipe;
  import hue_pkg::*;

  localparam int DW = 9;
  localparam int VW = 8;
  localparam int FW = 8;
  localparam int UW = 1;

  // clock / reset
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  hue_div_pipe_if #(.DIVIDEND_W(DW), .DIVISOR_W(VW), .FRAC_W(FW), .USER_W(UW)) bus0 ();
  hue_div_pipe_if #(.DIVIDEND_W(DW), .DIVISOR_W(VW), .FRAC_W(FW), .USER_W(UW)) bus1 ();

  assign bus1.en       = bus0.en;
  assign bus1.flush    = bus0.flush;
  assign bus1.valid    = bus0.valid;
  assign bus1.dividend = bus0.dividend;
  assign bus1.divisor  = bus0.divisor;
  assign bus1.user     = bus0.user;

  hue_div_pipe #(.DIVIDEND_W(DW), .DIVISOR_W(VW), .FRAC_W(FW), .ROUND(0), .USER_W(UW)) u_dut0 (
    .i_clk(clk), .i_rstn(rstn), .i_en(bus0.en), .i_flush(bus0.flush), .i_valid(bus0.valid),
    .i_dividend(bus0.dividend), .i_divisor(bus0.divisor), .i_user(bus0.user),
    .o_valid(bus0.o_valid), .o_quot(bus0.o_quot), .o_dbz(bus0.o_dbz), .o_user(bus0.o_user),
    .o_busy(bus0.o_busy)
  );

  hue_div_pipe #(.DIVIDEND_W(DW), .DIVISOR_W(VW), .FRAC_W(FW), .ROUND(1), .USER_W(UW)) u_dut1 (
    .i_clk(clk), .i_rstn(rstn), .i_en(bus1.en), .i_flush(bus1.flush), .i_valid(bus1.valid),
    .i_dividend(bus1.dividend), .i_divisor(bus1.divisor), .i_user(bus1.user),
    .o_valid(bus1.o_valid), .o_quot(bus1.o_quot), .o_dbz(bus1.o_dbz), .o_user(bus1.o_user),
    .o_busy(bus1.o_busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // integer reference: |a|*2^FW / d, optional half-away rounding, sign reapplied
  function automatic int model_q(input int a, input int d, input bit rnd);
    int n, q, r;
    if (d == 0) return 0;
    n = (a < 0 ? -a : a) * 256;
    q = n / d;
    r = n % d;
    if (rnd && (2 * r >= d)) q++;
    return (a < 0) ? -q : q;
  endfunction

  function automatic logic [19:0] pack(input logic u, input logic z, input int q);
    return {u, z, 18'(q)};
  endfunction

  // scoreboard
  logic [19:0] exp0_q[$];
  logic [19:0] exp1_q[$];
  logic        en_edge = 1'b0;
  int          run_len = 0;
  int          max_run = 0;

  always @(posedge clk) en_edge <= bus0.en;

  always @(negedge clk) begin
    if (rstn && en_edge) begin
      if (bus0.o_valid) begin
        if (exp0_q.size() == 0) chk("spurious0", 32'(bus0.o_valid), 32'd0);
        else chk("res0", 32'({bus0.o_user, bus0.o_dbz, bus0.o_quot}), 32'(exp0_q.pop_front()));
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
      if (bus1.o_valid) begin
        if (exp1_q.size() == 0) chk("spurious1", 32'(bus1.o_valid), 32'd0);
        else chk("res1", 32'({bus1.o_user, bus1.o_dbz, bus1.o_quot}), 32'(exp1_q.pop_front()));
      end
    end
  end

  // drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus0.valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic send(input int a, input int d, input logic u, input int e0, input int e1);
    bus0.valid    = 1'b1;
    bus0.dividend = DW'(a);
    bus0.divisor  = VW'(d);
    bus0.user     = u;
    exp0_q.push_back(pack(u, d == 0, e0));
    exp1_q.push_back(pack(u, d == 0, e1));
  endtask

  task automatic send_rand(input logic u);
    int a, d;
    a = int'($urandom_range(0, 511)) - 256;
    d = int'($urandom_range(0, 255));
    send(a, d, u, model_q(a, d, 1'b0), model_q(a, d, 1'b1));
  endtask

  task automatic drain();
    int t = 0;
    while ((exp0_q.size() != 0 || exp1_q.size() != 0) && t < 200) begin
      step();
      t++;
    end
    chk("drain", 32'(exp0_q.size() + exp1_q.size()), 32'd0);
  endtask

  // one sample, edges counted from the capturing edge until o_valid rises
  task automatic time_one(input int a, input int d, input int e0, input int e1,
                          input int stall_at, output int cyc);
    int left = 0;
    send(a, d, 1'b1, e0, e1);
    cyc = 0;
    while (cyc < 100) begin
      step();
      cyc++;
      bus0.valid = 1'b0;
      if (bus0.o_valid) break;
      if (cyc == stall_at) begin
        bus0.en = 1'b0;
        left = 5;
      end else if (left > 0) begin
        left--;
        if (left == 0) bus0.en = 1'b1;
      end
    end
    bus0.en = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [19:0] snap;
    logic        snap_v;
    bus0.en = 1'b1; bus0.flush = 1'b0; bus0.valid = 1'b0;
    bus0.dividend = '0; bus0.divisor = 8'd1; bus0.user = '0;

    #2;
    chk("rst_valid", 32'(bus0.o_valid), 32'd0);
    chk("rst_quot",  32'(bus0.o_quot),  32'd0);
    chk("rst_dbz",   32'(bus0.o_dbz),   32'd0);
    chk("rst_user",  32'(bus0.o_user),  32'd0);
    chk("rst_busy",  32'(bus0.o_busy),  32'd0);
    chk("rst_valid1", 32'(bus1.o_valid), 32'd0);
    @(posedge clk); #3 rstn = 1'b1;
    step();

    // directed vectors: dividend, divisor, user, truncated, rounded
    send(100, 200, 1'b1, 128, 128);         step();
    send(-60, 120, 1'b1, -128, -128);       step();
    send(2, 3, 1'b1, 170, 171);             step();
    send(-2, 3, 1'b1, -170, -171);          step();
    send(1, 3, 1'b1, 85, 85);               step();
    send(-256, 1, 1'b1, -65536, -65536);    step();
    send(255, 1, 1'b1, 65280, 65280);       step();
    send(0, 7, 1'b1, 0, 0);                 step();
    send(50, 0, 1'b1, 0, 0);                step();
    send(1, 255, 1'b0, 1, 1);               step();
    idle(0);
    drain();
    idle(2);

    time_one(100, 200, 128, 128, 0, cyc);
    chk("latency", 32'(cyc), 32'd19);
    drain(); idle(2);
    time_one(-2, 3, -170, -171, 5, cyc);
    chk("latency_stall", 32'(cyc), 32'd24);
    drain(); idle(2);

    // back-to-back throughput
    max_run = 0;
    for (int i = 0; i < 64; i++) begin
      send_rand(1'(i));
      step();
    end
    idle(0);
    drain();
    chk("thru_run", 32'(max_run), 32'd64);
    idle(2);

    // stall mid-stream; the sample offered while stalled must be dropped
    for (int i = 0; i < 30; i++) begin
      if (i == 25) begin
        bus0.en = 1'b0;
        bus0.valid = 1'b1; bus0.dividend = 9'd77; bus0.divisor = 8'd3;
        snap   = {bus0.o_user, bus0.o_dbz, bus0.o_quot};
        snap_v = bus0.o_valid;
        for (int s = 0; s < 5; s++) begin
          step();
          chk("stall_data",  32'({bus0.o_user, bus0.o_dbz, bus0.o_quot}), 32'(snap));
          chk("stall_valid", 32'(bus0.o_valid), 32'(snap_v));
        end
        bus0.en = 1'b1;
      end
      send_rand(1'(i));
      step();
    end
    idle(0);
    drain();
    idle(2);

    // flush with enable; the sample presented alongside is discarded
    for (int i = 0; i < 10; i++) begin
      send_rand(1'b1);
      step();
    end
    bus0.flush = 1'b1; bus0.valid = 1'b1; bus0.dividend = 9'd5; bus0.divisor = 8'd1;
    step();
    bus0.flush = 1'b0; bus0.valid = 1'b0;
    exp0_q.delete(); exp1_q.delete();
    chk("flush_valid", 32'(bus0.o_valid), 32'd0);
    chk("flush_busy",  32'(bus0.o_busy),  32'd0);
    chk("flush_quot",  32'(bus0.o_quot),  32'd0);
    idle(10);
    chk("flush_quiet", 32'(bus0.o_valid), 32'd0);
    time_one(255, 1, 65280, 65280, 0, cyc);
    chk("latency_flush", 32'(cyc), 32'd19);
    drain(); idle(2);

    // flush overrides a low enable
    for (int i = 0; i < 8; i++) begin
      send_rand(1'b0);
      step();
    end
    bus0.valid = 1'b0; bus0.en = 1'b0; bus0.flush = 1'b1;
    step();
    bus0.flush = 1'b0; bus0.en = 1'b1;
    exp0_q.delete(); exp1_q.delete();
    chk("flush_noen_busy",  32'(bus0.o_busy),  32'd0);
    chk("flush_noen_valid", 32'(bus1.o_valid), 32'd0);
    idle(25);
    chk("flush_noen_idle", 32'(bus0.o_busy), 32'd0);

    // asynchronous reset mid-stream
    for (int i = 0; i < 22; i++) begin
      send_rand(1'b1);
      step();
    end
    bus0.valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("arst_valid",  32'(bus0.o_valid), 32'd0);
    chk("arst_quot",   32'(bus0.o_quot),  32'd0);
    chk("arst_busy",   32'(bus0.o_busy),  32'd0);
    chk("arst_valid1", 32'(bus1.o_valid), 32'd0);
    exp0_q.delete(); exp1_q.delete();
    @(posedge clk); @(posedge clk); #3 rstn = 1'b1;
    idle(25);
    chk("arst_idle_busy",  32'(bus0.o_busy),  32'd0);
    chk("arst_idle_valid", 32'(bus0.o_valid), 32'd0);
    time_one(0, 7, 0, 0, 0, cyc);
    chk("latency_arst", 32'(cyc), 32'(hue_div_latency(DW, FW)));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
